// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON datapath.
// Holds the 5x64 state word array and the capture-slot FSM encoding.
package ascon_pack;

    localparam int CIPHER_W = 64;
    localparam int TAG_W    = 128;

    typedef logic [63:0] type_state [0:4];

    typedef enum logic {
        CAP_EMPTY,
        CAP_FULL
    } type_cap_fsm;

endpackage

// File: rtl/ascon_state_capture_if.sv
// Host-side handshake bundle of the state capture block:
// cipher word and tag channels, each with valid/ready.
interface ascon_state_capture_if;
    import ascon_pack::*;

    logic [CIPHER_W-1:0] cipher_o;
    logic                cipher_valid_o;
    logic                cipher_ready_i;
    logic [TAG_W-1:0]    tag_o;
    logic                tag_valid_o;
    logic                tag_ready_i;
    logic                tag_match_o;

    modport slave (
        output cipher_o,
        output cipher_valid_o,
        input  cipher_ready_i,
        output tag_o,
        output tag_valid_o,
        input  tag_ready_i,
        output tag_match_o
    );

    modport master (
        input  cipher_o,
        input  cipher_valid_o,
        output cipher_ready_i,
        input  tag_o,
        input  tag_valid_o,
        output tag_ready_i,
        input  tag_match_o
    );

endinterface

// File: rtl/cap_slot.sv
// One-entry capture register with valid/ready output handshake.
// A capture while full and not being drained is dropped and flagged.
module cap_slot
    import ascon_pack::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         capture,
    input  logic         ready,
    input  logic [W-1:0] data,
    output logic [W-1:0] q,
    output logic         valid,
    output logic         accept,
    output logic         overrun
);

    type_cap_fsm st;

    assign valid = (st == CAP_FULL);

    // Draining and refilling in the same cycle counts as an accept.
    assign accept  = capture & ~clear & (~valid | ready);
    assign overrun = capture & ~clear & valid & ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= CAP_EMPTY;
            q  <= '0;
        end else if (clear) begin
            st <= CAP_EMPTY;
        end else if (accept) begin
            st <= CAP_FULL;
            q  <= data;
        end else if (valid && ready) begin
            st <= CAP_EMPTY;
        end
    end

endmodule

// File: rtl/ascon_state_capture.sv
// State register after the end-of-permutation XOR, plus cipher/tag
// capture towards the host with optional tag compare.
module ascon_state_capture
    import ascon_pack::type_state;
    import ascon_pack::CIPHER_W;
#(
    parameter int BLK_CNT_W = 8,
    parameter int TAG_W     = 128
) (
    input  logic                 clock_i,
    input  logic                 resetb_i,
    input  type_state            state_i,
    input  logic                 en_reg_state_i,
    input  logic                 en_cipher_i,
    input  logic                 en_tag_i,
    input  logic                 decrypt_i,
    input  logic [TAG_W-1:0]     tag_exp_i,
    input  logic                 clear_i,
    output type_state            state_o,
    output logic [BLK_CNT_W-1:0] blk_cnt_o,
    output logic                 overrun_o,
    ascon_state_capture_if.slave host
);

    logic [TAG_W-1:0] tag_word;
    logic             c_acc;
    logic             c_ovr;
    logic             t_acc;
    logic             t_ovr;

    assign tag_word = {state_i[3], state_i[4]};

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_o <= '{default: '0};
        end else if (en_reg_state_i) begin
            state_o <= state_i;
        end
    end

    cap_slot #(
        .W (CIPHER_W)
    ) u_cipher (
        .clk     (clock_i),
        .rst_n   (resetb_i),
        .clear   (clear_i),
        .capture (en_cipher_i),
        .ready   (host.cipher_ready_i),
        .data    (state_i[0]),
        .q       (host.cipher_o),
        .valid   (host.cipher_valid_o),
        .accept  (c_acc),
        .overrun (c_ovr)
    );

    cap_slot #(
        .W (TAG_W)
    ) u_tag (
        .clk     (clock_i),
        .rst_n   (resetb_i),
        .clear   (clear_i),
        .capture (en_tag_i),
        .ready   (host.tag_ready_i),
        .data    (tag_word),
        .q       (host.tag_o),
        .valid   (host.tag_valid_o),
        .accept  (t_acc),
        .overrun (t_ovr)
    );

    // Counter, sticky overrun and compare result follow slot accepts.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            blk_cnt_o        <= '0;
            overrun_o        <= 1'b0;
            host.tag_match_o <= 1'b0;
        end else if (clear_i) begin
            blk_cnt_o        <= '0;
            overrun_o        <= 1'b0;
            host.tag_match_o <= 1'b0;
        end else begin
            if (c_acc) begin
                blk_cnt_o <= blk_cnt_o + BLK_CNT_W'(1);
            end
            if (c_ovr || t_ovr) begin
                overrun_o <= 1'b1;
            end
            if (t_acc) begin
                host.tag_match_o <= decrypt_i & (tag_word == tag_exp_i);
            end
        end
    end

endmodule

// File: tb/tb_ascon_state_capture.sv
// Randomized and directed bench for ascon_state_capture with a
// queue-based scoreboard checked from an independent monitor.
module tb_ascon_state_capture;
    import ascon_pack::*;

    typedef struct packed {
        logic [127:0] tag;
        logic         match;
    } tag_item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    type_state    state_i;
    type_state    state_o;
    logic         en_r, en_c, en_t, dec, clr;
    logic [127:0] tag_exp;
    logic [7:0]   blk_cnt;
    logic         overrun;

    ascon_state_capture_if hif();

    ascon_state_capture #(
        .BLK_CNT_W (8),
        .TAG_W     (128)
    ) dut (
        .clock_i        (clk),
        .resetb_i       (rst_n),
        .state_i        (state_i),
        .en_reg_state_i (en_r),
        .en_cipher_i    (en_c),
        .en_tag_i       (en_t),
        .decrypt_i      (dec),
        .tag_exp_i      (tag_exp),
        .clear_i        (clr),
        .state_o        (state_o),
        .blk_cnt_o      (blk_cnt),
        .overrun_o      (overrun),
        .host           (hif)
    );

    int           nvec = 0;
    int           nerr = 0;
    logic [63:0]  q_c[$];
    tag_item_t    q_t[$];
    logic [7:0]   m_cnt = '0;
    logic         m_ovr = 1'b0;
    logic [319:0] m_state = '0;

    function automatic logic [319:0] flat(input type_state s);
        return {s[0], s[1], s[2], s[3], s[4]};
    endfunction

    task automatic chk(input string n, input logic [319:0] a,
                       input logic [319:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Monitor: outputs observed mid-cycle; a valid&ready pair pops.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cipher_valid", hif.cipher_valid_o, q_c.size() != 0);
            if (hif.cipher_valid_o && q_c.size() != 0) begin
                chk("cipher_data", hif.cipher_o, q_c[0]);
                if (hif.cipher_ready_i) void'(q_c.pop_front());
            end
            chk("tag_valid", hif.tag_valid_o, q_t.size() != 0);
            if (hif.tag_valid_o && q_t.size() != 0) begin
                chk("tag_data", hif.tag_o, q_t[0].tag);
                chk("tag_match", hif.tag_match_o, q_t[0].match);
                if (hif.tag_ready_i) void'(q_t.pop_front());
            end
            chk("blk_cnt", blk_cnt, m_cnt);
            chk("overrun", overrun, m_ovr);
            chk("state", flat(state_o), m_state);
        end
    end

    // Drive one cycle at posedge+2, commit the model at the next edge.
    task automatic cyc(input logic r, input logic c, input logic t,
                       input logic d, input logic rc, input logic rt,
                       input logic cl, input type_state s,
                       input logic [127:0] te);
        logic         c_acc, t_acc, c_ov, t_ov;
        logic [127:0] tw;
        state_i = s;
        en_r = r;
        en_c = c;
        en_t = t;
        dec = d;
        clr = cl;
        tag_exp = te;
        hif.cipher_ready_i = rc;
        hif.tag_ready_i = rt;
        tw = {s[3], s[4]};
        c_acc = c && !cl && (q_c.size() == 0 || rc);
        c_ov  = c && !cl && q_c.size() != 0 && !rc;
        t_acc = t && !cl && (q_t.size() == 0 || rt);
        t_ov  = t && !cl && q_t.size() != 0 && !rt;
        @(posedge clk);
        if (r) m_state = flat(s);
        if (cl) begin
            q_c.delete();
            q_t.delete();
            m_cnt = '0;
            m_ovr = 1'b0;
        end else begin
            if (c_acc) begin
                q_c.push_back(s[0]);
                m_cnt = m_cnt + 8'd1;
            end
            if (t_acc) q_t.push_back(tag_item_t'{tw, d && (tw == te)});
            if (c_ov || t_ov) m_ovr = 1'b1;
        end
        #2;
    endtask

    task automatic idle(input logic rc, input logic rt);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, rc, rt, 1'b0, state_i, tag_exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_cipher", hif.cipher_o, 64'd0);
        chk("rst_cvalid", hif.cipher_valid_o, 1'b0);
        chk("rst_tag", hif.tag_o, 128'd0);
        chk("rst_tvalid", hif.tag_valid_o, 1'b0);
        chk("rst_match", hif.tag_match_o, 1'b0);
        chk("rst_cnt", blk_cnt, 8'd0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_state", flat(state_o), 320'd0);
        q_c.delete();
        q_t.delete();
        m_cnt = '0;
        m_ovr = 1'b0;
        m_state = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic type_state rnd_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    type_state    s0, s1, sc;
    logic [127:0] te;

    initial begin
        state_i = '{default: '0};
        {en_r, en_c, en_t, dec, clr} = '0;
        tag_exp = '0;
        hif.cipher_ready_i = 1'b0;
        hif.tag_ready_i = 1'b0;
        #2;
        do_reset();

        s0 = '{64'h0123456789ABCDEF, {16{4'h1}}, {16{4'h2}},
               {16{4'h3}}, {16{4'h4}}};
        cyc(1, 0, 0, 0, 0, 0, 0, s0, '0);
        chk("state_load", flat(state_o), flat(s0));
        cyc(0, 0, 0, 0, 0, 0, 0, rnd_state(), '0);
        chk("state_hold", flat(state_o), flat(s0));

        sc = s0;
        sc[0] = 64'hDEADBEEFCAFEF00D;
        cyc(0, 1, 0, 0, 0, 0, 0, sc, '0);
        chk("c_valid", hif.cipher_valid_o, 1'b1);
        chk("c_word", hif.cipher_o, 64'hDEADBEEFCAFEF00D);
        chk("c_cnt1", blk_cnt, 8'd1);
        for (int i = 0; i < 3; i++) begin
            idle(0, 0);
            chk("c_stall", hif.cipher_o, 64'hDEADBEEFCAFEF00D);
        end
        sc[0] = 64'd1;
        cyc(0, 1, 0, 0, 0, 0, 0, sc, '0);
        chk("ovr_keep", hif.cipher_o, 64'hDEADBEEFCAFEF00D);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_cnt", blk_cnt, 8'd1);
        cyc(0, 1, 0, 0, 1, 0, 0, sc, '0);
        chk("sim_word", hif.cipher_o, 64'd1);
        chk("sim_cnt", blk_cnt, 8'd2);
        chk("sim_ovr", overrun, 1'b1);
        idle(1, 0);
        chk("c_drain", hif.cipher_valid_o, 1'b0);

        s1 = s0;
        s1[3] = {16{4'hA, 4'h5}};
        s1[4] = {16{4'h5, 4'hA}};
        te = {s1[3], s1[4]};
        cyc(0, 0, 1, 1, 0, 1, 0, s1, te);
        chk("t_valid", hif.tag_valid_o, 1'b1);
        chk("t_word", hif.tag_o, te);
        chk("t_match", hif.tag_match_o, 1'b1);
        cyc(0, 0, 1, 1, 0, 1, 0, s1, te ^ 128'd1);
        chk("t_nomatch", hif.tag_match_o, 1'b0);
        cyc(0, 0, 1, 1, 0, 1, 0, s1, te);
        chk("t_match2", hif.tag_match_o, 1'b1);
        cyc(0, 0, 1, 0, 0, 1, 0, s1, te);
        chk("t_encrypt", hif.tag_match_o, 1'b0);
        idle(0, 1);
        chk("t_drain", hif.tag_valid_o, 1'b0);

        for (int i = 0; i < 400; i++) begin
            s1 = rnd_state();
            te = ($urandom_range(0, 1) == 0) ? {s1[3], s1[4]}
                                             : {s1[3], s1[4] ^ 64'd1};
            cyc(1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 15) == 0, s1, te);
        end

        do_reset();

        cyc(0, 0, 0, 0, 0, 0, 1, s0, '0);
        for (int i = 0; i < 256; i++) begin
            cyc(0, 1, 0, 0, 1, 0, 0, rnd_state(), '0);
        end
        chk("wrap_cnt", blk_cnt, 8'd0);
        idle(1, 1);

        cyc(1, 1, 0, 0, 0, 0, 0, s0, '0);
        cyc(0, 1, 0, 0, 0, 0, 0, rnd_state(), '0);
        s1 = s0;
        s1[3] = {16{4'hA, 4'h5}};
        s1[4] = {16{4'h5, 4'hA}};
        cyc(0, 0, 1, 1, 0, 0, 0, s1, {s1[3], s1[4]});
        chk("pre_clr_ovr", overrun, 1'b1);
        chk("pre_clr_match", hif.tag_match_o, 1'b1);
        cyc(0, 1, 1, 1, 0, 0, 1, rnd_state(), '0);
        chk("clr_cvalid", hif.cipher_valid_o, 1'b0);
        chk("clr_tvalid", hif.tag_valid_o, 1'b0);
        chk("clr_cnt", blk_cnt, 8'd0);
        chk("clr_ovr", overrun, 1'b0);
        chk("clr_match", hif.tag_match_o, 1'b0);
        chk("clr_state", flat(state_o), flat(s0));
        idle(0, 0);
        idle(1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ascon_state_capture.md
Name: ascon_state_capture

Overview:
- Sits directly downstream of the end-of-permutation XOR stage (key/LSB injection).
- Registers the 320-bit ASCON state produced by that stage, and the registered state feeds back to the next round's input.
- Extracts 64-bit cipher words from the rate and the 128-bit tag from words 3/4.
- Presents cipher words and the tag to the host through valid/ready handshakes; optionally compares the tag against an expected value (decrypt mode).

Parameters:
- BLK_CNT_W, 8, width of the cipher-block counter.
- TAG_W, 128, tag width; fixed at 128, kept for checks only.

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous active-low reset.
- state_i  in  type_state (5x64)  state from the end-of-permutation XOR stage.
- en_reg_state_i  in  1  load state_i into the state register.
- en_cipher_i  in  1  capture state_i[0] as a cipher word.
- en_tag_i  in  1  capture {state_i[3],state_i[4]} as the tag.
- decrypt_i  in  1  1 = compare the tag instead of only outputting it.
- tag_exp_i  in  128  expected tag, sampled together with en_tag_i.
- clear_i  in  1  synchronous clear of flags, counter and valids.
- state_o  out  type_state  registered state.
- cipher_o  out  64  captured cipher word.
- cipher_valid_o  out  1  cipher_o holds an unconsumed word.
- cipher_ready_i  in  1  host accepts the cipher word.
- tag_o  out  128  captured tag.
- tag_valid_o  out  1  tag_o holds an unconsumed tag.
- tag_ready_i  in  1  host accepts the tag.
- tag_match_o  out  1  compare result; meaningful when tag_valid_o=1 and the tag was captured in decrypt mode.
- blk_cnt_o  out  BLK_CNT_W  number of cipher words captured since reset/clear.
- overrun_o  out  1  sticky flag: a capture arrived while the previous item was unconsumed.

Behaviour:
- Reset (resetb_i=0, asynchronous) forces the following to 0: state_o, cipher_o, cipher_valid_o, tag_o, tag_valid_o, tag_match_o, blk_cnt_o, overrun_o.
- State register: when en_reg_state_i=1, state_o <= state_i at the rising edge (latency 1). Otherwise state_o holds its value.
- Cipher path handshake FSM, states C_EMPTY and C_FULL:
  - C_EMPTY & en_cipher_i: cipher_o <= state_i[0], go to C_FULL, blk_cnt_o +1.
  - C_FULL & cipher_ready_i & !en_cipher_i: go to C_EMPTY.
  - C_FULL & cipher_ready_i & en_cipher_i: simultaneous consume and capture. Load the new word, stay in C_FULL, count +1, no overrun.
  - C_FULL & !cipher_ready_i & en_cipher_i: keep the old word (do not overwrite), set overrun_o, counter unchanged.
  - cipher_valid_o = (state == C_FULL).
- blk_cnt_o wraps modulo 2^BLK_CNT_W with no flag.
- Tag path FSM, states T_EMPTY and T_FULL, uses the same rules with en_tag_i/tag_ready_i. On capture:
  - tag_o <= {state_i[3],state_i[4]}.
  - tag_match_o <= decrypt_i & ({state_i[3],state_i[4]} == tag_exp_i).
  - tag_match_o is held until the next capture or clear.
- Encrypt mode: tag_match_o is captured as 0.
- In decrypt mode tag_o is still presented, and the host may ignore it.
- en_reg_state_i, en_cipher_i and en_tag_i are independent and may all be high in the same cycle. Each acts on the same state_i sample.
- clear_i (synchronous) does the following; the state register is unaffected:
  - Returns both FSMs to EMPTY.
  - Zeroes blk_cnt_o, overrun_o and tag_match_o.
  - clear_i has priority over all enables in the same cycle.
- Reset asserted mid-handshake drops the valids immediately (asynchronously). No word is replayed after reset.
- overrun_o is cleared only by reset or clear_i.

Decomposition:
- ascon_pack already provides type_state (array [0:4] of logic[63:0]).
- Add to ascon_pack:
  - enum type_cap_fsm {CAP_EMPTY, CAP_FULL}.
  - Constants CIPHER_W=64 and TAG_W=128.
- One natural sub-module: cap_slot, parameterised by data width. It implements the EMPTY/FULL register with valid/ready, the capture-while-full overrun pulse, and simultaneous consume+capture.
- Instantiate cap_slot twice (64-bit cipher, 128-bit tag). The counter, compare and sticky flag stay at top level.

Test Plan:
- Reset and state load:
  - Assert resetb_i=0 mid-run: all outputs read 0.
  - Release reset, drive state_i words = 0x0123456789ABCDEF, 0x1111..., 0x2222..., 0x3333..., 0x4444..., with en_reg_state_i=1 for one cycle: state_o equals state_i one cycle later and holds afterwards.
- Cipher handshake:
  - en_cipher_i pulse with state_i[0]=0xDEADBEEFCAFEF00D: cipher_valid_o=1 the next cycle, blk_cnt_o=1.
  - Hold cipher_ready_i=0 for 3 cycles: valid stays, data stable.
  - Assert cipher_ready_i=1: valid drops the cycle after.
- Overrun and simultaneous capture:
  - Second capture (0x1) while FULL with ready=0: cipher_o keeps 0xDEADBEEFCAFEF00D, overrun_o=1, blk_cnt_o=1.
  - Capture with ready=1 in the same cycle: cipher_o=0x1, blk_cnt_o=2, overrun_o unchanged.
- Tag decrypt compare:
  - decrypt_i=1, state_i[3]=0xA5A5A5A5A5A5A5A5, state_i[4]=0x5A5A5A5A5A5A5A5A, tag_exp_i equal: tag_match_o=1.
  - Repeat with tag_exp_i bit 0 flipped: tag_match_o=0.
  - Encrypt mode (decrypt_i=0): tag_match_o=0.
- Counter wrap and clear:
  - 256 consumed cipher captures with BLK_CNT_W=8: blk_cnt_o returns to 0.
  - clear_i together with en_cipher_i: both valids=0, blk_cnt_o=0, overrun_o=0, state_o unchanged.
